// File: rtl/alu_issue_stage.sv
// Operand FIFO that feeds an external 2-bit combinational ALU, followed by a
// result register that hands each ALU result to a consumer with valid/ready.
module alu_issue_stage #(
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_a,
   input  logic [1:0]               in_b,
   input  logic [1:0]               in_s,
   output logic [1:0]               alu_a,
   output logic [1:0]               alu_b,
   output logic [1:0]               alu_s,
   input  logic [3:0]               alu_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_y,
   output logic [1:0]               out_s,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CW-1:0]            done_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_LEVEL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   LVL_ONE    = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] s;
   } entry_t;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   state_t        state_q;
   state_t        state_d;
   logic          push;
   logic          pop;
   logic          deliver;

   // Full blocks input even when a pop happens in the same cycle.
   assign in_ready = (level < FULL_LEVEL);
   assign push     = in_valid & in_ready & ~clr;
   assign pop      = (level != '0) & (~out_valid | out_ready) & ~clr;
   assign deliver  = out_valid & out_ready;

   // NOTE: storage has no reset; an entry is only visible once level counts it,
   // and the ALU inputs are forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: in_a, b: in_b, s: in_s};
      end
   end

   // NOTE: every process that infers a flop uses non-blocking assignments, so
   // all state updates see the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // NOTE: combinational outputs get a default before any condition so no
   // path through the block leaves them unassigned, which would infer a latch.
   always_comb begin
      head  = mem[rd_ptr];
      alu_a = 2'b00;
      alu_b = 2'b00;
      alu_s = 2'b00;
      if (level != '0) begin
         alu_a = head.a;
         alu_b = head.b;
         alu_s = head.s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         out_y <= '0;
         out_s <= '0;
      end else if (pop) begin
         out_y <= alu_y;
         out_s <= head.s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) state_q <= ST_EMPTY;
      else            state_q <= state_d;
   end

   // Result-register occupancy: refilled back-to-back whenever a pop is possible.
   always_comb begin
      state_d   = state_q;
      out_valid = (state_q == ST_FULL);
      case (state_q)
         ST_EMPTY: if (pop) state_d = ST_FULL;
         ST_FULL: begin
            if (pop)            state_d = ST_FULL;
            else if (out_ready) state_d = ST_EMPTY;
         end
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Deliveries are counted even in a flush cycle; only rst clears the count.
   always_ff @(posedge clk) begin
      if (rst)          done_cnt <= '0;
      else if (deliver) done_cnt <= done_cnt + CNT_ONE;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: hand sequences, a table of ALU vectors and random
// traffic, all compared against a queue-based reference model every cycle.
module tb_alu_issue_stage;

   localparam int DEPTH   = 4;
   localparam int CW      = 8;
   localparam int CNT_MOD = 1 << CW;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_a;
   logic [1:0] in_b;
   logic [1:0] in_s;
   logic [1:0] alu_a;
   logic [1:0] alu_b;
   logic [1:0] alu_s;
   logic [3:0] alu_y;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_y;
   logic [1:0] out_s;
   logic [2:0] level;
   logic [7:0] done_cnt;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] s;
   } op_t;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] s;
      logic [3:0] y;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   op_t  q[$];
   bit   m_valid;
   logic [3:0] m_y;
   logic [1:0] m_s;
   int   m_done;
   vec_t vecs[8];
   op_t  fill_ops[6];
   int   saved;

   alu_issue_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_s(in_s),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_s(out_s),
      .level(level), .done_cnt(done_cnt)
   );

   // The external ALU: mult / add / nand / pass-A, zero-extended to 4 bits.
   function automatic logic [3:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] s);
      int ia;
      int ib;
      ia = a;
      ib = b;
      case (s)
         2'd0:    return 4'(ia * ib);
         2'd1:    return 4'(ia + ib);
         2'd2:    return {2'b00, ~(a & b)};
         default: return {2'b00, a};
      endcase
   endfunction

   assign alu_y = alu_fn(alu_a, alu_b, alu_s);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      op_t e;
      bit  push;
      bit  pop;
      bit  deliver;
      if (rst) begin
         q.delete();
         m_valid = 0; m_y = 0; m_s = 0; m_done = 0;
         return;
      end
      push    = in_valid && (q.size() < DEPTH);
      pop     = (q.size() != 0) && (!m_valid || out_ready);
      deliver = m_valid && out_ready;
      if (deliver) m_done = (m_done + 1) % CNT_MOD;
      if (clr) begin
         q.delete();
         m_valid = 0; m_y = 0; m_s = 0;
         return;
      end
      if (pop) begin
         e       = q.pop_front();
         m_y     = alu_fn(e.a, e.b, e.s);
         m_s     = e.s;
         m_valid = 1;
      end else if (deliver) begin
         m_valid = 0;
      end
      if (push) q.push_back('{a: in_a, b: in_b, s: in_s});
   endtask

   task automatic compare_all();
      op_t h;
      h = '{a: 2'd0, b: 2'd0, s: 2'd0};
      if (q.size() != 0) h = q[0];
      check("in_ready",  in_ready,  q.size() < DEPTH);
      check("out_valid", out_valid, m_valid);
      check("out_y",     out_y,     m_y);
      check("out_s",     out_s,     m_s);
      check("level",     level,     q.size());
      check("done_cnt",  done_cnt,  m_done);
      check("alu_a",     alu_a,     h.a);
      check("alu_b",     alu_b,     h.b);
      check("alu_s",     alu_s,     h.s);
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge,
   // and the caller changes inputs afterwards.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
      in_a = a; in_b = b; in_s = s;
   endtask

   initial begin
      vecs[0] = '{a: 2'd3, b: 2'd2, s: 2'd0, y: 4'd6};
      vecs[1] = '{a: 2'd3, b: 2'd3, s: 2'd0, y: 4'd9};
      vecs[2] = '{a: 2'd2, b: 2'd3, s: 2'd1, y: 4'd5};
      vecs[3] = '{a: 2'd3, b: 2'd3, s: 2'd1, y: 4'd6};
      vecs[4] = '{a: 2'd1, b: 2'd2, s: 2'd2, y: 4'd3};
      vecs[5] = '{a: 2'd3, b: 2'd3, s: 2'd2, y: 4'd0};
      vecs[6] = '{a: 2'd2, b: 2'd1, s: 2'd3, y: 4'd2};
      vecs[7] = '{a: 2'd0, b: 2'd3, s: 2'd3, y: 4'd0};

      rst = 1; clr = 0; in_valid = 0; out_ready = 0;
      set_op(0, 0, 0);

      // Reset held for two cycles.
      step(); step();
      rst = 0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_done_cnt", done_cnt, 0);
      check("rst_alu_abs", {alu_a, alu_b, alu_s}, 0);

      // Single multiply, consumer always ready.
      in_valid = 1; out_ready = 1; set_op(3, 2, 0);
      step();
      in_valid = 0;
      step();
      check("single_out_valid", out_valid, 1);
      check("single_out_y", out_y, 6);
      check("single_out_s", out_s, 0);
      step();
      check("single_done_cnt", done_cnt, 1);
      check("single_drained", out_valid, 0);

      // Table of ALU vectors through the full path.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; out_ready = 1;
         set_op(vecs[i].a, vecs[i].b, vecs[i].s);
         step();
         in_valid = 0;
         step();
         check("vec_out_valid", out_valid, 1);
         check("vec_out_y", out_y, vecs[i].y);
         check("vec_out_s", out_s, vecs[i].s);
         step();
      end

      // Fill with consumer stalled: one result parked, four queued, sixth refused.
      out_ready = 0;
      for (int i = 0; i < 6; i++) begin
         fill_ops[i] = '{a: 2'($urandom_range(0, 3)), b: 2'($urandom_range(0, 3)),
                         s: 2'(i % 4)};
         in_valid = 1;
         set_op(fill_ops[i].a, fill_ops[i].b, fill_ops[i].s);
         step();
         if (i == 4) begin
            check("fill_level_full", level, 4);
            check("fill_in_ready", in_ready, 0);
         end
      end
      in_valid = 0;
      check("fill_level_held", level, 4);
      check("fill_out_valid", out_valid, 1);
      check("fill_first_result", out_y, alu_fn(fill_ops[0].a, fill_ops[0].b, fill_ops[0].s));

      // Stream out in push order, one per cycle.
      out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("stream_level", level, 3 - k);
         check("stream_out_y", out_y,
               alu_fn(fill_ops[k+1].a, fill_ops[k+1].b, fill_ops[k+1].s));
         check("stream_out_valid", out_valid, 1);
      end
      step();
      check("stream_drained", out_valid, 0);

      // Simultaneous push/pop at level 2, counter wraps after 300 deliveries.
      rst = 1; step(); rst = 0;
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         step();
      end
      check("sim_level_start", level, 2);
      out_ready = 1;
      for (int i = 0; i < 300; i++) begin
         set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         step();
         check("sim_level", level, 2);
      end
      check("sim_done_wrap", done_cnt, 44);
      in_valid = 0;
      for (int i = 0; i < 4; i++) step();

      // Flush mid-stream keeps the counter.
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_op(2'(i), 2'd3, 2'd1);
         step();
      end
      in_valid = 0;
      check("clr_pre_level", level, 3);
      saved = m_done;
      clr = 1; step(); clr = 0;
      check("clr_level", level, 0);
      check("clr_out_valid", out_valid, 0);
      check("clr_out_y", out_y, 0);
      check("clr_done_kept", done_cnt, saved);

      // Flush during a delivery still counts that delivery.
      in_valid = 1; set_op(1, 1, 1);
      step(); step();
      in_valid = 0;
      out_ready = 1; clr = 1;
      saved = m_done;
      step(); clr = 0;
      check("clr_deliver_counted", done_cnt, (saved + 1) % CNT_MOD);
      check("clr_deliver_valid", out_valid, 0);

      // Reset mid-stream clears the counter too.
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_op(2'd3, 2'(i), 2'd0);
         step();
      end
      in_valid = 0;
      rst = 1; step(); rst = 0;
      check("rst_mid_level", level, 0);
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_done", done_cnt, 0);

      // Random traffic with phases of mostly-stalled and mostly-ready consumer.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 60) == 0);
         rst       = ($urandom_range(0, 400) == 0);
         set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         step();
      end
      rst = 0; clr = 0; in_valid = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
